ptp_rtc_evt_mch: RTL and testbench

//  Parametrised PTPv2 real-time counter: {seconds, nanoseconds, fraction} accumulator advanced by tick_inc.

---
 rtl/ptp_rtc_evt_mch_if.sv | 34 +++
 rtl/ptp_rtc_evt_mch.sv | 200 ++++++++++++++++++++
 tb/tb_ptp_rtc_evt_mch.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ptp_rtc_evt_mch_if.sv
// Port bundle for the PTP real-time counter: time control/adjust inputs, time/PPS outputs
// and per-channel event capture handshake. slave = counter side, master = register/test side.
interface ptp_rtc_evt_mch_if #(
    parameter int SC_W  = 48,
    parameter int N_EVT = 2
);
    logic [31:0]                tick_inc_i;
    logic [SC_W-1:0]            sc_ofst_i;
    logic [31:0]                ns_ofst_i;
    logic                       load_i;
    logic                       clear_i;
    logic                       adj_vld_i;
    logic [31:0]                adj_ns_i;
    logic                       adj_busy_o;
    logic [SC_W+31:0]           rtc_std_o;
    logic                       pps_o;
    logic [N_EVT-1:0]           evt_i;
    logic [N_EVT-1:0]           evt_ack_i;
    logic [N_EVT-1:0]           evt_vld_o;
    logic [N_EVT-1:0]           evt_ovf_o;
    logic [N_EVT*(SC_W+32)-1:0] evt_ts_o;

    modport slave (
        input  tick_inc_i, sc_ofst_i, ns_ofst_i, load_i, clear_i, adj_vld_i, adj_ns_i,
        input  evt_i, evt_ack_i,
        output adj_busy_o, rtc_std_o, pps_o, evt_vld_o, evt_ovf_o, evt_ts_o
    );

    modport master (
        output tick_inc_i, sc_ofst_i, ns_ofst_i, load_i, clear_i, adj_vld_i, adj_ns_i,
        output evt_i, evt_ack_i,
        input  adj_busy_o, rtc_std_o, pps_o, evt_vld_o, evt_ovf_o, evt_ts_o
    );
endinterface

// File: rtl/ptp_rtc_evt_mch.sv
// PTPv2 RTC {sc, ns, frac} with load/clear/phase adjust, PPS and N-channel event timestamp capture.
// Latency: time registered (1 cycle); event capture valid 3 cycles after evt_i reaches the synchroniser.
// Backpressure: a full event channel drops new edges and flags evt_ovf_o until acked. RTC_SLEW_EN selects slewed adjust.
module ptp_rtc_evt_mch #(
    parameter int SC_W      = 48,
    parameter int FRAC_W    = 26,
    parameter int N_EVT     = 2,
    parameter int PPS_HI_NS = 500_000_000
) (
    input  logic              rtc_clk,
    input  logic              rst_n,
    ptp_rtc_evt_mch_if.slave  bus
);
    localparam int TW = SC_W + 32;
    localparam int AW = FRAC_W + 34;
    localparam logic signed [33:0] NS_PER_S = 34'sd1_000_000_000;
    localparam logic [31:0]        PPS_HI   = 32'(PPS_HI_NS);

    typedef enum logic {EV_IDLE = 1'b0, EV_FULL = 1'b1} ev_st_e;

    logic [SC_W-1:0]       sc_q, sc_d;
    logic [29:0]           ns_q, ns_d;
    logic [FRAC_W-1:0]     frac_q, frac_d;
    logic                  roll_q, roll_d;
    logic                  pps_q, pps_d;
    logic signed [31:0]    delta;
    logic signed [AW-1:0]  sum_s;
    logic signed [33:0]    sum_ns;

    // delta is the whole-ns correction folded into this cycle's tick
`ifdef RTC_SLEW_EN
    logic signed [31:0] rem_q, rem_d;

    always_comb begin
        delta = '0;
        if (rem_q > 32'sd0)
            delta = 32'sd1;
        else if (rem_q < 32'sd0)
            delta = -32'sd1;
        rem_d = rem_q - delta;
        if (bus.clear_i)
            rem_d = '0;
        else if (bus.load_i)
            rem_d = rem_q;
        else if (bus.adj_vld_i)
            rem_d = $signed(bus.adj_ns_i);
    end

    always_ff @(posedge rtc_clk or negedge rst_n) begin
        if (!rst_n)
            rem_q <= '0;
        else
            rem_q <= rem_d;
    end

    assign bus.adj_busy_o = (rem_q != 32'sd0);
`else
    always_comb begin
        delta = '0;
        if (bus.adj_vld_i)
            delta = $signed(bus.adj_ns_i);
    end

    assign bus.adj_busy_o = 1'b0;
`endif

    always_comb begin
        sum_s = $signed({4'b0000, ns_q, frac_q})
              + $signed({{(AW-32){1'b0}}, bus.tick_inc_i})
              + $signed({{2{delta[31]}}, delta, {FRAC_W{1'b0}}});
        sum_ns = sum_s[AW-1:FRAC_W];
        frac_d = sum_s[FRAC_W-1:0];
        sc_d   = sc_q;
        ns_d   = 30'(sum_ns);
        roll_d = 1'b0;
        // |adj| < 1 s, so a single borrow or carry always normalises
        if (sum_ns < 34'sd0) begin
            ns_d = 30'(sum_ns + NS_PER_S);
            sc_d = sc_q - SC_W'(1);
        end else if (sum_ns >= NS_PER_S) begin
            ns_d   = 30'(sum_ns - NS_PER_S);
            sc_d   = sc_q + SC_W'(1);
            roll_d = 1'b1;
        end

        pps_d = pps_q;
        if (roll_q)
            pps_d = 1'b1;
        else if ({2'b00, ns_d} >= PPS_HI)
            pps_d = 1'b0;

        if (bus.clear_i) begin
            sc_d   = '0;
            ns_d   = '0;
            frac_d = '0;
            roll_d = 1'b0;
            pps_d  = 1'b0;
        end else if (bus.load_i) begin
            sc_d   = bus.sc_ofst_i;
            ns_d   = (bus.ns_ofst_i < 32'd1_000_000_000) ? bus.ns_ofst_i[29:0] : '0;
            frac_d = '0;
            roll_d = 1'b0;
            pps_d  = 1'b0;
        end
    end

    always_ff @(posedge rtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q   <= '0;
            ns_q   <= '0;
            frac_q <= '0;
            roll_q <= 1'b0;
            pps_q  <= 1'b0;
        end else begin
            sc_q   <= sc_d;
            ns_q   <= ns_d;
            frac_q <= frac_d;
            roll_q <= roll_d;
            pps_q  <= pps_d;
        end
    end

    assign bus.rtc_std_o = {sc_q, 2'b00, ns_q};
    assign bus.pps_o     = pps_q;

    logic [N_EVT-1:0] ev_s1_q, ev_s2_q, ev_s3_q;
    logic [N_EVT-1:0] ev_edge, cap_en, ovf_set, vld, ovf_q;
    ev_st_e           st_q [N_EVT];
    ev_st_e           st_d [N_EVT];
    logic [TW-1:0]    ts_q [N_EVT];
    logic [N_EVT*TW-1:0] ts_flat;

    assign ev_edge = ev_s2_q & ~ev_s3_q;

    always_ff @(posedge rtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_s1_q <= '0;
            ev_s2_q <= '0;
            ev_s3_q <= '0;
            for (int n = 0; n < N_EVT; n++)
                st_q[n] <= EV_IDLE;
        end else begin
            ev_s1_q <= bus.evt_i;
            ev_s2_q <= ev_s1_q;
            ev_s3_q <= ev_s2_q;
            for (int n = 0; n < N_EVT; n++)
                st_q[n] <= st_d[n];
        end
    end

    always_comb begin
        for (int n = 0; n < N_EVT; n++) begin
            st_d[n] = st_q[n];
            case (st_q[n])
                EV_IDLE: if (ev_edge[n]) st_d[n] = EV_FULL;
                EV_FULL: if (bus.evt_ack_i[n] && !ev_edge[n]) st_d[n] = EV_IDLE;
                default: st_d[n] = EV_IDLE;
            endcase
        end
    end

    // an ack in the same cycle as an edge frees the slot for that edge
    always_comb begin
        vld     = '0;
        cap_en  = '0;
        ovf_set = '0;
        for (int n = 0; n < N_EVT; n++) begin
            vld[n]     = (st_q[n] == EV_FULL);
            cap_en[n]  = ev_edge[n] && ((st_q[n] == EV_IDLE) || bus.evt_ack_i[n]);
            ovf_set[n] = ev_edge[n] && (st_q[n] == EV_FULL) && !bus.evt_ack_i[n];
        end
    end

    always_ff @(posedge rtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
            for (int n = 0; n < N_EVT; n++)
                ts_q[n] <= '0;
        end else begin
            for (int n = 0; n < N_EVT; n++) begin
                if (cap_en[n])
                    ts_q[n] <= bus.rtc_std_o;
                if (bus.evt_ack_i[n])
                    ovf_q[n] <= 1'b0;
                else if (ovf_set[n])
                    ovf_q[n] <= 1'b1;
            end
        end
    end

    always_comb begin
        ts_flat = '0;
        for (int n = 0; n < N_EVT; n++)
            ts_flat[n*TW +: TW] = ts_q[n];
    end

    assign bus.evt_vld_o = vld;
    assign bus.evt_ovf_o = ovf_q;
    assign bus.evt_ts_o  = ts_flat;
endmodule

// File: tb/tb_ptp_rtc_evt_mch.sv
// Bench for ptp_rtc_evt_mch: directed scenarios plus randomized traffic checked against
// a reference built on a single fixed-point ns-of-second value and event sample history.
module tb_ptp_rtc_evt_mch;
    localparam longint NS_FX = 64'sd1_000_000_000 * 64'sd67108864;
    localparam longint HI_NS = 64'sd500_000_000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ptp_rtc_evt_mch_if #(.SC_W(48), .N_EVT(2)) bus ();

    ptp_rtc_evt_mch #(.SC_W(48), .FRAC_W(26), .N_EVT(2), .PPS_HI_NS(500_000_000)) dut (
        .rtc_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_chk;
    int n_fail;

    logic [47:0] msc;
    longint      mnsf;
    bit          mpps, mpend;
    int          mrem;
    logic [1:0]  mvld, movf;
    logic [79:0] mts [2];
    logic [1:0]  eh1, eh2, eh3;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] exp_rtc();
        return {msc, 2'b00, 30'(mnsf >>> 26)};
    endfunction

    task automatic model_reset();
        msc = '0; mnsf = 0; mpps = 0; mpend = 0; mrem = 0;
        mvld = '0; movf = '0; mts[0] = '0; mts[1] = '0;
        eh1 = '0; eh2 = '0; eh3 = '0;
    endtask

    task automatic model_step();
        logic [79:0] cur;
        logic [1:0]  edg;
        longint      d;
        bit          np;
        cur = exp_rtc();
        edg = eh2 & ~eh3;
        for (int n = 0; n < 2; n++) begin
            if (edg[n]) begin
                if (!mvld[n] || bus.evt_ack_i[n]) begin
                    mts[n] = cur; mvld[n] = 1'b1; movf[n] = 1'b0;
                end else
                    movf[n] = 1'b1;
            end else if (bus.evt_ack_i[n]) begin
                mvld[n] = 1'b0; movf[n] = 1'b0;
            end
        end
        eh3 = eh2; eh2 = eh1; eh1 = bus.evt_i;

        if (bus.clear_i) begin
            msc = '0; mnsf = 0; mpps = 0; mpend = 0; mrem = 0;
        end else if (bus.load_i) begin
            msc  = bus.sc_ofst_i;
            mnsf = (bus.ns_ofst_i < 32'd1_000_000_000) ? (longint'(bus.ns_ofst_i) <<< 26) : 0;
            mpps = 0; mpend = 0;
        end else begin
            d = longint'(bus.tick_inc_i);
`ifdef RTC_SLEW_EN
            if (mrem > 0) begin d += 64'sd1 <<< 26; mrem--; end
            else if (mrem < 0) begin d -= 64'sd1 <<< 26; mrem++; end
            if (bus.adj_vld_i) mrem = $signed(bus.adj_ns_i);
`else
            if (bus.adj_vld_i) d += longint'($signed(bus.adj_ns_i)) <<< 26;
`endif
            mnsf += d;
            np = 0;
            if (mnsf < 0) begin mnsf += NS_FX; msc = msc - 48'd1; end
            else if (mnsf >= NS_FX) begin mnsf -= NS_FX; msc = msc + 48'd1; np = 1; end
            if (mpend) mpps = 1;
            else if ((mnsf >>> 26) >= HI_NS) mpps = 0;
            mpend = np;
        end
    endtask

    task automatic compare_all();
        chk("rtc",  bus.rtc_std_o, exp_rtc());
        chk("pps",  bus.pps_o, mpps);
        chk("vld",  bus.evt_vld_o, mvld);
        chk("ovf",  bus.evt_ovf_o, movf);
        chk("ts",   bus.evt_ts_o, {mts[1], mts[0]});
        chk("busy", bus.adj_busy_o, mrem != 0);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        bus.load_i = 1'b0; bus.clear_i = 1'b0; bus.adj_vld_i = 1'b0; bus.evt_ack_i = '0;
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] snap;
        int cnt;
        int r;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.tick_inc_i = '0; bus.sc_ofst_i = '0; bus.ns_ofst_i = '0;
        bus.load_i = 1'b0; bus.clear_i = 1'b0; bus.adj_vld_i = 1'b0; bus.adj_ns_i = '0;
        bus.evt_i = '0; bus.evt_ack_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rtc", bus.rtc_std_o, '0);
        chk("rst_pps", bus.pps_o, 1'b0);
        chk("rst_vld", bus.evt_vld_o, 2'b00);
        chk("rst_ts", bus.evt_ts_o, '0);
        rst_n = 1'b1;

        // T1: offset load then 1000 ticks of 6.4 ns
        bus.tick_inc_i = 32'h1999_999a;
        bus.sc_ofst_i = 48'h11_1234_5678; bus.ns_ofst_i = 32'h0150_0000; bus.load_i = 1'b1;
        cyc();
        chk("t1_load", bus.rtc_std_o, {48'h11_1234_5678, 32'h0150_0000});
        repeat (1000) cyc();
        chk("t1_ns", bus.rtc_std_o[31:0], 32'h0150_1900);
        chk("t1_sc", bus.rtc_std_o[79:32], 48'h11_1234_5678);

        // T2: rollover and PPS
        bus.sc_ofst_i = 48'd5; bus.ns_ofst_i = 32'd999_999_990; bus.load_i = 1'b1;
        cyc(); cyc(); cyc();
        chk("t2_ns", bus.rtc_std_o[31:0], 32'd2);
        chk("t2_sc", bus.rtc_std_o[79:32], 48'd6);
        chk("t2_pps_lag", bus.pps_o, 1'b0);
        cyc();
        chk("t2_pps_hi", bus.pps_o, 1'b1);
`ifndef RTC_SLEW_EN
        bus.adj_ns_i = 32'd499_999_000; bus.adj_vld_i = 1'b1;
        cyc();
        cnt = 0;
        while (bus.rtc_std_o[31:0] < 32'd500_000_000 && cnt < 500) begin
            chk("t2_pps_hold", bus.pps_o, 1'b1);
            cyc();
            cnt++;
        end
        chk("t2_reach", bus.rtc_std_o[31:0] >= 32'd500_000_000, 1'b1);
        chk("t2_pps_clr", bus.pps_o, 1'b0);
`endif

        // T3: clear while running with pps high, then clear+load
        bus.sc_ofst_i = 48'd9; bus.ns_ofst_i = 32'd999_999_990; bus.load_i = 1'b1;
        repeat (4) cyc();
        chk("t3_pps_pre", bus.pps_o, 1'b1);
        bus.clear_i = 1'b1;
        cyc();
        chk("t3_clr_rtc", bus.rtc_std_o, '0);
        chk("t3_clr_pps", bus.pps_o, 1'b0);
        repeat (5) cyc();
        bus.clear_i = 1'b1; bus.load_i = 1'b1; bus.sc_ofst_i = 48'd123; bus.ns_ofst_i = 32'd456;
        cyc();
        chk("t3_clr_load", bus.rtc_std_o, '0);

        // T4: event channel 1 capture, overflow, ack, ack+edge
        bus.evt_i = 2'b10;
        cyc(); cyc();
        chk("t4_vld_early", bus.evt_vld_o[1], 1'b0);
        snap = exp_rtc();
        cyc();
        chk("t4_vld", bus.evt_vld_o[1], 1'b1);
        chk("t4_ts", bus.evt_ts_o[159:80], snap);
        bus.evt_i = 2'b00; cyc(); cyc();
        bus.evt_i = 2'b10; repeat (3) cyc();
        chk("t4_ovf", bus.evt_ovf_o[1], 1'b1);
        chk("t4_ts_held", bus.evt_ts_o[159:80], snap);
        bus.evt_ack_i = 2'b10;
        cyc();
        chk("t4_ack_vld", bus.evt_vld_o[1], 1'b0);
        chk("t4_ack_ovf", bus.evt_ovf_o[1], 1'b0);
        bus.evt_i = 2'b00; cyc(); cyc();
        bus.evt_i = 2'b10; repeat (3) cyc();
        bus.evt_i = 2'b00; cyc(); cyc();
        bus.evt_i = 2'b10; cyc(); cyc();
        snap = exp_rtc();
        bus.evt_ack_i = 2'b10;
        cyc();
        chk("t4_ackedge_vld", bus.evt_vld_o[1], 1'b1);
        chk("t4_ackedge_ovf", bus.evt_ovf_o[1], 1'b0);
        chk("t4_ackedge_ts", bus.evt_ts_o[159:80], snap);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.tick_inc_i = $urandom_range(32'h3fff_ffff, 32'h0800_0000);
            if ($urandom_range(0, 127) == 0) bus.clear_i = 1'b1;
            if ($urandom_range(0, 31) == 0) begin
                bus.load_i = 1'b1;
                bus.sc_ofst_i = 48'({$urandom(), $urandom()});
                r = $urandom_range(0, 3);
                if (r == 0) bus.ns_ofst_i = $urandom();
                else if (r == 1) bus.ns_ofst_i = $urandom_range(999_999_999, 999_999_900);
                else bus.ns_ofst_i = $urandom_range(999_999_999, 0);
            end
            if ($urandom_range(0, 15) == 0) begin
                bus.adj_vld_i = 1'b1;
                bus.adj_ns_i = $urandom_range(999_999_999, 0);
                if ($urandom_range(0, 1) == 1) bus.adj_ns_i = -bus.adj_ns_i;
            end
            if ($urandom_range(0, 7) == 0) bus.evt_i[$urandom_range(0, 1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) bus.evt_ack_i = 2'($urandom_range(0, 3));
            cyc();
        end

        // T5: phase adjust across a second boundary
        bus.tick_inc_i = 32'h1999_999a; bus.evt_i = '0; bus.clear_i = 1'b1;
        cyc();
        bus.sc_ofst_i = 48'd10; bus.ns_ofst_i = 32'd1000; bus.load_i = 1'b1;
        cyc();
`ifndef RTC_SLEW_EN
        bus.adj_ns_i = -32'sd2000; bus.adj_vld_i = 1'b1;
        cyc();
        chk("t5_ns", bus.rtc_std_o[31:0], 32'd999_999_006);
        chk("t5_sc", bus.rtc_std_o[79:32], 48'd9);
        chk("t5_busy", bus.adj_busy_o, 1'b0);
`else
        bus.adj_ns_i = -32'sd100; bus.adj_vld_i = 1'b1;
        cyc();
        cnt = 0;
        while (bus.adj_busy_o && cnt < 300) begin
            cnt++;
            cyc();
        end
        chk("t5_busy_cycles", 32'(cnt), 32'd100);
        chk("t5_slew_ns", bus.rtc_std_o[31:0], 32'd1546);
`endif

        // T6: asynchronous reset mid-run with pps/vld (and busy) set
        bus.sc_ofst_i = 48'd7; bus.ns_ofst_i = 32'd999_999_990; bus.load_i = 1'b1;
        cyc();
        bus.evt_i = 2'b01;
        repeat (4) cyc();
`ifdef RTC_SLEW_EN
        bus.adj_ns_i = -32'sd50; bus.adj_vld_i = 1'b1;
        cyc();
        chk("t6_pre_busy", bus.adj_busy_o, 1'b1);
`endif
        chk("t6_pre_pps", bus.pps_o, 1'b1);
        chk("t6_pre_vld", bus.evt_vld_o[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rtc", bus.rtc_std_o, '0);
        chk("t6_pps", bus.pps_o, 1'b0);
        chk("t6_vld", bus.evt_vld_o, 2'b00);
        chk("t6_ovf", bus.evt_ovf_o, 2'b00);
        chk("t6_ts", bus.evt_ts_o, '0);
        chk("t6_busy", bus.adj_busy_o, 1'b0);
        bus.evt_i = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) cyc();
        chk("t6_resume", bus.rtc_std_o, {48'd0, 32'd128});

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
